pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter STALL_W, default 16: width of the stall-cycle counter.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low; asserting it clears all state immediately.
REQ-004 ir_s0  input  16  instruction word presented by stage0 this cycle.
REQ-005 ir_valid  input  1  ir_s0 holds a real instruction.
REQ-006 stall_s0  output  1  stage0 holds PC and ir this cycle.
REQ-007 issue  output  1  ir_s0 advances into stage1 at the next edge.
REQ-008 bubble_s1  output  1  stage1 receives {OPNOP,11'h000} instead of ir_s0.
REQ-009 valid_s  output  3  occupancy of stages 1,2,3, bit0 = stage1.
REQ-010 wb_en, wb_dest  output  1, 4  stage3 register write enable and destination.
REQ-011 z_pending  output  1  an in-flight instruction will update Z.
REQ-012 halt  output  1  processor halted; sticky until reset.
REQ-013 stall_cnt  output  STALL_W  saturating count of cycles with stall_s0=1 in RUN/STALL.

Function
REQ-014 Scoreboard SHALL keep one entry per stage 1..3: valid, dest[3:0], wr (writes Rd), setz (CC==S), wpc (wr and dest==15); entries shift 1->2->3->retire every cycle.
REQ-015 wr SHALL be 1 for all opcodes except STR, SYS, NOP, PRE.
REQ-016 Sources of ir_s0: Rd always, except for SYS, NOP, PRE; op2 register when IMM==0 and opcode is not PRE.
REQ-017 RAW hazard: any valid entry in stages 1..3 with wr=1 and dest equal to a source; there is no bypass, so stage3 counts.
REQ-018 Z hazard: ir_s0 CC is NE or EQ and any valid entry has setz=1.
REQ-019 PC hazard: any valid entry has wpc=1.
REQ-020 issue=1 iff state RUN/STALL, ir_valid=1, opcode != SYS, and no RAW, Z or PC hazard.
REQ-021 When issue=0, stage1 entry SHALL load invalid and bubble_s1=1; stall_s0=1 whenever ir_valid=1 and issue=0.
REQ-022 When ir_valid=0 and no hazard applies, the controller SHALL send a bubble with stall_s0=0.
REQ-023 Maximum stall for a RAW hazard is 3 cycles; a PRE followed by its consumer SHALL never be separated by a bubble unless the consumer has a hazard.
REQ-024 States: RUN (no stall last cycle), STALL (hazard hold), DRAIN (SYS seen), HALTED.
REQ-025 RUN->STALL on hazard; STALL->RUN when issue=1; RUN/STALL->DRAIN when ir_valid=1 and the opcode is SYS; DRAIN->HALTED when valid_s==0; HALTED is terminal.
REQ-026 In DRAIN and HALTED: issue=0, stall_s0=1, bubble_s1=1; in-flight entries still retire.
REQ-027 halt=1 exactly in HALTED, asserted the cycle after valid_s reaches 0.
REQ-028 wb_en = valid3 & wr3; wb_dest = dest3.
REQ-029 z_pending = OR of valid & setz over stages 1..3.
REQ-030 stall_cnt SHALL increment on stall_s0=1 in RUN/STALL only and SHALL hold at all-ones.

Reset
REQ-031 On reset=0: state RUN; scoreboard all invalid; stall_s0=0, issue=0, bubble_s1=1, valid_s=0, wb_en=0, wb_dest=0, z_pending=0, halt=0, stall_cnt=0.
REQ-032 A reset during STALL, DRAIN or HALTED SHALL discard all in-flight entries without a writeback pulse.

Structure
REQ-033 Opcode, CC and field-slice constants SHALL come from the shared processor package used by the stage modules; state encoding is local.
REQ-034 A single sub-module, hazard_detect, SHALL be combinational and map ir_s0 plus the scoreboard to raw, zhaz and pchaz.

Verification
REQ-035 ADD R1,R2 then ADD R3,R1 back-to-back: 3 bubble cycles; the second instruction issues on the cycle wb_dest=1 has retired; stall_cnt=3.
REQ-036 ADD.S R1,R2 then MOV.NE R4,#1: the MOV is held while z_pending=1 and issues the cycle after z_pending falls.
REQ-037 MOV R15,#8 then any instruction: stall_s0=1 until the R15 entry retires, then normal issue resumes.
REQ-038 Three independent ADDs then SYS: DRAIN for 3 cycles, halt=1 on the 4th, and no further issue.
REQ-039 reset pulsed low mid-STALL with 2 entries valid: all outputs reach reset values immediately; no wb_en pulse afterwards.
REQ-040 Force 70000 consecutive hazard cycles with STALL_W=16: stall_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared processor definitions: instruction field layout, opcodes, condition codes
// and the per-stage scoreboard entry used by the hazard controller.
package pipe_hazard_ctrl_pkg;

  // Instruction word: [15:11] opcode, [10:9] cc, [8] imm, [7:4] rd, [3:0] op2
  localparam int OP_LSB  = 11;
  localparam int CC_LSB  = 9;
  localparam int IMM_BIT = 8;
  localparam int RD_LSB  = 4;
  localparam int OP2_LSB = 0;

  localparam logic [4:0] OPNOP = 5'h00;
  localparam logic [4:0] OPADD = 5'h01;
  localparam logic [4:0] OPSUB = 5'h02;
  localparam logic [4:0] OPAND = 5'h03;
  localparam logic [4:0] OPORR = 5'h04;
  localparam logic [4:0] OPMOV = 5'h05;
  localparam logic [4:0] OPLDR = 5'h06;
  localparam logic [4:0] OPSTR = 5'h07;
  localparam logic [4:0] OPPRE = 5'h08;
  localparam logic [4:0] OPSYS = 5'h1F;

  localparam logic [1:0] CC_AL = 2'd0;
  localparam logic [1:0] CC_EQ = 2'd1;
  localparam logic [1:0] CC_NE = 2'd2;
  localparam logic [1:0] CC_S  = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [3:0] dest;
    logic       wr;
    logic       setz;
    logic       wpc;
  } sb_entry_t;

  function automatic logic [4:0] ir_op(input logic [15:0] ir);
    return ir[OP_LSB +: 5];
  endfunction

  function automatic logic [1:0] ir_cc(input logic [15:0] ir);
    return ir[CC_LSB +: 2];
  endfunction

  function automatic logic ir_imm(input logic [15:0] ir);
    return ir[IMM_BIT];
  endfunction

  function automatic logic [3:0] ir_rd(input logic [15:0] ir);
    return ir[RD_LSB +: 4];
  endfunction

  function automatic logic [3:0] ir_op2(input logic [15:0] ir);
    return ir[OP2_LSB +: 4];
  endfunction

  function automatic logic writes_rd(input logic [4:0] op);
    return !(op == OPSTR || op == OPSYS || op == OPNOP || op == OPPRE);
  endfunction

  function automatic sb_entry_t make_entry(input logic [15:0] ir);
    sb_entry_t e;
    e.valid = 1'b1;
    e.dest  = ir_rd(ir);
    e.wr    = writes_rd(ir_op(ir));
    e.setz  = (ir_cc(ir) == CC_S);
    e.wpc   = e.wr && (e.dest == 4'hF);
    return e;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational hazard check of the stage0 instruction against the three
// in-flight scoreboard entries (no bypass, so stage3 still counts).
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [15:0]     ir_i,
  input  sb_entry_t [2:0] sb_i,
  output logic            raw_o,
  output logic            zhaz_o,
  output logic            pchaz_o
);

  logic [4:0] op;
  logic [3:0] rd;
  logic [3:0] op2;
  logic       use_rd;
  logic       use_op2;
  logic       reads_z;
  logic       raw;
  logic       zhaz;
  logic       pchaz;

  always_comb begin
    op      = ir_op(ir_i);
    rd      = ir_rd(ir_i);
    op2     = ir_op2(ir_i);
    use_rd  = !(op == OPSYS || op == OPNOP || op == OPPRE);
    use_op2 = !ir_imm(ir_i) && (op != OPPRE);
    reads_z = (ir_cc(ir_i) == CC_EQ) || (ir_cc(ir_i) == CC_NE);
    raw     = 1'b0;
    zhaz    = 1'b0;
    pchaz   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (sb_i[i].valid && sb_i[i].wr &&
          ((use_rd && sb_i[i].dest == rd) || (use_op2 && sb_i[i].dest == op2)))
        raw = 1'b1;
      if (sb_i[i].valid && sb_i[i].setz && reads_z)
        zhaz = 1'b1;
      if (sb_i[i].valid && sb_i[i].wpc)
        pchaz = 1'b1;
    end
  end

  assign raw_o   = raw;
  assign zhaz_o  = zhaz;
  assign pchaz_o = pchaz;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Issue/stall controller for a 4-stage in-order pipe: tracks stages 1..3 in a
// shifting scoreboard, holds stage0 on hazards and drains to halt on SYS.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        ir_s0,
  input  logic               ir_valid,
  output logic               stall_s0,
  output logic               issue,
  output logic               bubble_s1,
  output logic [2:0]         valid_s,
  output logic               wb_en,
  output logic [3:0]         wb_dest,
  output logic               z_pending,
  output logic               halt,
  output logic [STALL_W-1:0] stall_cnt,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  state_e             state_q;
  sb_entry_t [2:0]    sb_q, sb_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               raw, zhaz, pchaz;
  logic               active;
  logic               is_sys;

  hazard_detect u_hazard_detect (
    .ir_i   (ir_s0),
    .sb_i   (sb_q),
    .raw_o  (raw),
    .zhaz_o (zhaz),
    .pchaz_o(pchaz)
  );

  // Gating with reset keeps the combinational outputs at their reset values
  // while reset is held, not just after the next edge.
  assign active    = (state_q == ST_RUN) || (state_q == ST_STALL);
  assign is_sys    = (ir_op(ir_s0) == OPSYS);
  assign issue     = reset && active && ir_valid && !is_sys && !(raw || zhaz || pchaz);
  assign stall_s0  = reset && (!active || (ir_valid && !issue));
  assign bubble_s1 = !issue;

  assign valid_s   = {sb_q[2].valid, sb_q[1].valid, sb_q[0].valid};
  assign wb_en     = sb_q[2].valid && sb_q[2].wr;
  assign wb_dest   = sb_q[2].dest;
  assign z_pending = (sb_q[0].valid && sb_q[0].setz) || (sb_q[1].valid && sb_q[1].setz) ||
                     (sb_q[2].valid && sb_q[2].setz);
  assign halt      = (state_q == ST_HALTED);
  assign stall_cnt = stall_cnt_q;
  assign dbg_state = state_q;

  always_comb begin
    sb_d        = sb_q;
    sb_d[0]     = issue ? make_entry(ir_s0) : '0;
    sb_d[1]     = sb_q[0];
    sb_d[2]     = sb_q[1];
    stall_cnt_d = stall_cnt_q;
    if (active && stall_s0 && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      sb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
      case (state_q)
        ST_RUN, ST_STALL: begin
          if (ir_valid && is_sys) state_q <= ST_DRAIN;
          else if (stall_s0)      state_q <= ST_STALL;
          else                    state_q <= ST_RUN;
        end
        ST_DRAIN: if (valid_s == 3'b000) state_q <= ST_HALTED;
        default:  state_q <= ST_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; a second small-counter instance
// shares the stimulus so counter saturation is reachable in a short run.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ir_s0 = '0;
  logic        ir_valid = 1'b0;

  logic        stall_s0, issue, bubble_s1, wb_en, z_pending, halt;
  logic [2:0]  valid_s;
  logic [3:0]  wb_dest;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;

  logic        stall_s0_b, issue_b, bubble_s1_b, wb_en_b, z_pending_b, halt_b;
  logic [2:0]  valid_s_b;
  logic [3:0]  wb_dest_b;
  logic [5:0]  stall_cnt_b;
  logic [1:0]  dbg_state_b;

  int          n_chk = 0;
  int          n_err = 0;
  logic [3:0]  exp_q[$];

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
    $fatal(1);
  end

  pipe_hazard_ctrl #(.STALL_W(16)) dut (
    .clk(clk), .reset(reset), .ir_s0(ir_s0), .ir_valid(ir_valid),
    .stall_s0(stall_s0), .issue(issue), .bubble_s1(bubble_s1), .valid_s(valid_s),
    .wb_en(wb_en), .wb_dest(wb_dest), .z_pending(z_pending), .halt(halt),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  pipe_hazard_ctrl #(.STALL_W(6)) dut_small (
    .clk(clk), .reset(reset), .ir_s0(ir_s0), .ir_valid(ir_valid),
    .stall_s0(stall_s0_b), .issue(issue_b), .bubble_s1(bubble_s1_b), .valid_s(valid_s_b),
    .wb_en(wb_en_b), .wb_dest(wb_dest_b), .z_pending(z_pending_b), .halt(halt_b),
    .stall_cnt(stall_cnt_b), .dbg_state(dbg_state_b)
  );

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [1:0] cc,
                                      input logic imm, input logic [3:0] rd,
                                      input logic [3:0] op2);
    return {op, cc, imm, rd, op2};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [15:0] ir, input logic v);
    ir_s0    = ir;
    ir_valid = v;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    ir_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    logic [15:0] add_1_2, add_3_1, add_1_1, adds_1_2, movne_4, pre_4, add_5_6;
    logic [15:0] mov_15, add_6_7, str_1_2, mov_1_5, add_3_4, add_7_8, sys_i, add_5_1;
    add_1_2  = enc(OPADD, CC_AL, 1'b0, 4'd1, 4'd2);
    add_3_1  = enc(OPADD, CC_AL, 1'b0, 4'd3, 4'd1);
    add_1_1  = enc(OPADD, CC_AL, 1'b0, 4'd1, 4'd1);
    adds_1_2 = enc(OPADD, CC_S,  1'b0, 4'd1, 4'd2);
    movne_4  = enc(OPMOV, CC_NE, 1'b1, 4'd4, 4'd1);
    pre_4    = enc(OPPRE, CC_AL, 1'b0, 4'd4, 4'd4);
    add_5_6  = enc(OPADD, CC_AL, 1'b0, 4'd5, 4'd6);
    mov_15   = enc(OPMOV, CC_AL, 1'b1, 4'd15, 4'd8);
    add_6_7  = enc(OPADD, CC_AL, 1'b0, 4'd6, 4'd7);
    str_1_2  = enc(OPSTR, CC_AL, 1'b0, 4'd1, 4'd2);
    mov_1_5  = enc(OPMOV, CC_AL, 1'b1, 4'd1, 4'd5);
    add_3_4  = enc(OPADD, CC_AL, 1'b0, 4'd3, 4'd4);
    add_7_8  = enc(OPADD, CC_AL, 1'b0, 4'd7, 4'd8);
    add_5_1  = enc(OPADD, CC_AL, 1'b0, 4'd5, 4'd1);
    sys_i    = enc(OPSYS, CC_AL, 1'b1, 4'd0, 4'd0);

    // Reset values, with a valid instruction present that must not issue
    #1 reset = 1'b0;
    ir_s0 = add_1_2;
    ir_valid = 1'b1;
    @(posedge clk);
    #2;
    check("rst_issue", issue, 0);
    check("rst_stall", stall_s0, 0);
    check("rst_bubble", bubble_s1, 1);
    check("rst_valid_s", valid_s, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_dest", wb_dest, 0);
    check("rst_zpend", z_pending, 0);
    check("rst_halt", halt, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_state", dbg_state, 0);
    ir_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;

    // RAW through stage3: ADD R1,R2 ; ADD R3,R1
    step(add_1_2, 1'b1);
    check("raw_c0_issue", issue, 1);
    check("raw_c0_bubble", bubble_s1, 0);
    tick();
    step(add_3_1, 1'b1);
    check("raw_c1_issue", issue, 0);
    check("raw_c1_stall", stall_s0, 1);
    check("raw_c1_valid_s", valid_s, 3'b001);
    check("raw_c1_state", dbg_state, 0);
    tick();
    step(add_3_1, 1'b1);
    check("raw_c2_issue", issue, 0);
    check("raw_c2_valid_s", valid_s, 3'b010);
    check("raw_c2_state", dbg_state, 1);
    tick();
    step(add_3_1, 1'b1);
    check("raw_c3_issue", issue, 0);
    check("raw_c3_wb_en", wb_en, 1);
    check("raw_c3_wb_dest", wb_dest, 1);
    tick();
    step(add_3_1, 1'b1);
    check("raw_c4_issue", issue, 1);
    check("raw_c4_stall", stall_s0, 0);
    check("raw_c4_wb_en", wb_en, 0);
    check("raw_c4_stall_cnt", stall_cnt, 3);
    tick();
    step(16'h0000, 1'b0);
    check("idle_bubble", bubble_s1, 1);
    check("idle_stall", stall_s0, 0);
    check("idle_valid_s", valid_s, 3'b001);
    check("idle_state", dbg_state, 0);

    // Z hazard: ADD.S R1,R2 ; MOV.NE R4,#1 ; then PRE and its consumer
    do_reset();
    step(adds_1_2, 1'b1);
    check("z_c0_issue", issue, 1);
    tick();
    for (int c = 1; c <= 3; c++) begin
      step(movne_4, 1'b1);
      check($sformatf("z_c%0d_zpend", c), z_pending, 1);
      check($sformatf("z_c%0d_issue", c), issue, 0);
      tick();
    end
    step(movne_4, 1'b1);
    check("z_c4_zpend", z_pending, 0);
    check("z_c4_issue", issue, 1);
    tick();
    step(pre_4, 1'b1);
    check("pre_issue", issue, 1);
    check("pre_bubble", bubble_s1, 0);
    tick();
    step(add_5_6, 1'b1);
    check("pre_consumer_issue", issue, 1);
    check("pre_consumer_stall", stall_s0, 0);
    check("z_stall_cnt", stall_cnt, 3);

    // PC hazard, STR writes nothing, Rd is a source
    do_reset();
    step(mov_15, 1'b1);
    check("pc_c0_issue", issue, 1);
    tick();
    for (int c = 1; c <= 3; c++) begin
      step(add_6_7, 1'b1);
      check($sformatf("pc_c%0d_stall", c), stall_s0, 1);
      tick();
    end
    step(add_6_7, 1'b1);
    check("pc_c4_issue", issue, 1);
    tick();
    step(str_1_2, 1'b1);
    check("str_issue", issue, 1);
    tick();
    step(add_1_2, 1'b1);
    check("after_str_issue", issue, 1);
    tick();
    step(mov_1_5, 1'b1);
    check("rd_src_issue", issue, 0);
    check("rd_src_stall", stall_s0, 1);

    // Three independent ADDs then SYS: drain and halt
    do_reset();
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd5);
    step(add_1_2, 1'b1);
    check("sys_a0_issue", issue, 1);
    tick();
    step(add_3_4, 1'b1);
    check("sys_a1_issue", issue, 1);
    tick();
    step(add_5_6, 1'b1);
    check("sys_a2_issue", issue, 1);
    tick();
    step(sys_i, 1'b1);
    check("sys_c3_issue", issue, 0);
    check("sys_c3_stall", stall_s0, 1);
    check("sys_c3_valid_s", valid_s, 3'b111);
    check("sys_c3_wb_en", wb_en, 1);
    check("sys_c3_wb_dest", wb_dest, exp_q.pop_front());
    tick();
    step(add_7_8, 1'b1);
    check("drain1_state", dbg_state, 2);
    check("drain1_issue", issue, 0);
    check("drain1_bubble", bubble_s1, 1);
    check("drain1_valid_s", valid_s, 3'b110);
    check("drain1_wb_dest", wb_dest, exp_q.pop_front());
    tick();
    check("drain2_valid_s", valid_s, 3'b100);
    check("drain2_wb_dest", wb_dest, exp_q.pop_front());
    check("drain2_halt", halt, 0);
    tick();
    check("drain3_state", dbg_state, 2);
    check("drain3_valid_s", valid_s, 3'b000);
    check("drain3_halt", halt, 0);
    tick();
    check("halt_c7", halt, 1);
    check("halt_state", dbg_state, 3);
    check("halt_issue", issue, 0);
    check("halt_stall", stall_s0, 1);
    check("halt_stall_cnt", stall_cnt, 1);
    tick();
    tick();
    check("halt_sticky", halt, 1);
    check("halt_no_issue", issue, 0);
    check("halt_valid_s", valid_s, 3'b000);

    // Reset asserted mid-STALL with two entries in flight
    do_reset();
    step(add_1_2, 1'b1);
    tick();
    step(add_3_4, 1'b1);
    tick();
    step(add_5_1, 1'b1);
    check("mid_c2_issue", issue, 0);
    check("mid_c2_valid_s", valid_s, 3'b011);
    tick();
    step(add_5_1, 1'b1);
    check("mid_c3_state", dbg_state, 1);
    check("mid_c3_valid_s", valid_s, 3'b110);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_valid_s", valid_s, 0);
    check("mid_rst_stall", stall_s0, 0);
    check("mid_rst_issue", issue, 0);
    check("mid_rst_bubble", bubble_s1, 1);
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_wb_en", wb_en, 0);
    check("mid_rst_stall_cnt", stall_cnt, 0);
    ir_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(16'h0000, 1'b0);
      check($sformatf("post_rst%0d_wb_en", c), wb_en, 0);
      tick();
    end

    // Dependent chain: 30 issues and 90 stall cycles; small counter saturates
    do_reset();
    step(add_1_1, 1'b1);
    repeat (120) tick();
    check("chain_issue", issue, 1);
    check("chain_stall_cnt", stall_cnt, 90);
    check("sat_stall_cnt", stall_cnt_b, 6'h3F);
    tick();
    check("sat_hold", stall_cnt_b, 6'h3F);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
